dsp_io_bank: RTL and testbench

Parametrised frame I/O bank that sits between the sample-rate audio interfaces and the uDSP engine, replacing fixed 8-channel I/O wiring. On each frame_start it captures NCH input samples into a shadow bank and publishes the previous frame's double-buffered results. It then launches the DSP and tracks completion. The DSP reads the inputs and writes the outputs through memory-mapped windows on its data-memory ports, and frame overruns are detected and counted.

---
 rtl/dsp_io_bank.sv | 137 +++++++++++++
 tb/tb_dsp_io_bank.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dsp_io_bank.sv
// Frame I/O bank between the audio sample interfaces and the uDSP engine.
// Captures inputs into a shadow bank on each accepted frame, publishes the
// double-buffered DSP results, launches the DSP and counts frame overruns.
// The DSP sees the shadow bank as a read window and the back buffer as a
// write window on its data-memory ports.
module dsp_io_bank #(
  parameter int unsigned NCH     = 16,
  parameter int unsigned DWW     = 36,
  parameter int unsigned DAW     = 10,
  parameter logic [2:0]  IN_SEG  = 3'd6,
  parameter logic [2:0]  OUT_SEG = 3'd7,
  parameter int unsigned CW      = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     frame_start_i,
  input  logic                     bypass_i,
  input  logic [NCH-1:0][DWW-1:0]  inputs_i,
  output logic [NCH-1:0][DWW-1:0]  outputs_o,
  output logic                     dsp_start_o,
  input  logic                     dsp_done_i,
  output logic                     busy_o,
  input  logic [DAW-1:0]           rd_addr_i,
  output logic [DWW-1:0]           rd_data_o,
  output logic                     rd_hit_o,
  input  logic                     wr_en_i,
  input  logic [DAW-1:0]           wr_addr_i,
  input  logic [DWW-1:0]           wr_data_i,
  output logic [CW-1:0]            overrun_count_o
);

  localparam int unsigned IW = DAW - 3;
  // Channel count widened by one bit so NCH == 2**IW still compares correctly.
  localparam logic [IW:0] NchL = NCH[IW:0];

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLaunch = 2'd1;
  localparam logic [1:0] StRun    = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [NCH-1:0][DWW-1:0] shadow_q, shadow_d;
  logic [NCH-1:0][DWW-1:0] back_q, back_d;
  logic [NCH-1:0][DWW-1:0] outputs_q, outputs_d;
  logic [DWW-1:0]          rd_data_q, rd_data_d;
  logic                    rd_hit_q, rd_hit_d;
  logic [CW-1:0]           ovr_q, ovr_d;

  logic [2:0]    rd_seg, wr_seg;
  logic [IW-1:0] rd_idx, wr_idx;
  logic          wr_hit;
  logic          accept, overrun;

  assign rd_seg = rd_addr_i[DAW-1:DAW-3];
  assign rd_idx = rd_addr_i[IW-1:0];
  assign wr_seg = wr_addr_i[DAW-1:DAW-3];
  assign wr_idx = wr_addr_i[IW-1:0];
  assign wr_hit = wr_en_i && (wr_seg == OUT_SEG) && ({1'b0, wr_idx} < NchL);

  // A frame is taken when idle, or when it coincides with the DSP finishing.
  assign accept  = frame_start_i &&
                   ((state_q == StIdle) || ((state_q == StRun) && dsp_done_i));
  assign overrun = frame_start_i && !accept;

  // Frame sequencing: launch one cycle after accept, then wait for dsp_done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (accept) state_d = StLaunch;
      StLaunch: state_d = StRun;
      StRun: begin
        if (accept)          state_d = StLaunch;
        else if (dsp_done_i) state_d = StIdle;
      end
      default:  state_d = StIdle;
    endcase
  end

  // Back buffer writes, frame capture and output swap (write forwarded on accept).
  always_comb begin
    back_d    = back_q;
    shadow_d  = shadow_q;
    outputs_d = outputs_q;
    for (int i = 0; i < NCH; i++) begin
      if (wr_hit && (wr_idx == IW'(i))) back_d[i] = wr_data_i;
    end
    if (accept) begin
      shadow_d = inputs_i;
      for (int i = 0; i < NCH; i++) begin
        outputs_d[i] = bypass_i ? inputs_i[i] : back_d[i];
      end
    end
  end

  // Input window decode; reads see the shadow bank as of this cycle.
  always_comb begin
    rd_hit_d  = (rd_seg == IN_SEG) && ({1'b0, rd_idx} < NchL);
    rd_data_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_hit_d && (rd_idx == IW'(i))) rd_data_d = shadow_q[i];
    end
  end

  // Saturating overrun counter.
  always_comb begin
    ovr_d = ovr_q;
    if (overrun && (ovr_q != {CW{1'b1}})) ovr_d = ovr_q + CW'(1);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      shadow_q  <= '0;
      back_q    <= '0;
      outputs_q <= '0;
      rd_data_q <= '0;
      rd_hit_q  <= 1'b0;
      ovr_q     <= '0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      back_q    <= back_d;
      outputs_q <= outputs_d;
      rd_data_q <= rd_data_d;
      rd_hit_q  <= rd_hit_d;
      ovr_q     <= ovr_d;
    end
  end

  assign outputs_o       = outputs_q;
  assign dsp_start_o     = (state_q == StLaunch);
  assign busy_o          = (state_q == StLaunch) || (state_q == StRun);
  assign rd_data_o       = rd_data_q;
  assign rd_hit_o        = rd_hit_q;
  assign overrun_count_o = ovr_q;

endmodule

// File: tb/tb_dsp_io_bank.sv
// Directed bench for dsp_io_bank with NCH=8 and a 2-bit overrun counter.
module tb_dsp_io_bank;

  localparam int unsigned NCH = 8;
  localparam int unsigned DWW = 36;
  localparam int unsigned DAW = 10;
  localparam int unsigned CW  = 2;
  localparam logic [2:0]  INS = 3'd6;
  localparam logic [2:0]  OUTS = 3'd7;
  localparam int unsigned VW  = NCH * DWW;

  logic                    clk = 1'b0;
  logic                    reset, frame_start, bypass, dsp_done, wr_en;
  logic [NCH-1:0][DWW-1:0] inputs, outputs, exp_out;
  logic                    dsp_start, busy, rd_hit;
  logic [DAW-1:0]          rd_addr, wr_addr;
  logic [DWW-1:0]          rd_data, wr_data;
  logic [CW-1:0]           overrun_count;

  int nvec = 0;
  int nmis = 0;

  dsp_io_bank #(
    .NCH(NCH), .DWW(DWW), .DAW(DAW), .IN_SEG(INS), .OUT_SEG(OUTS), .CW(CW)
  ) dut (
    .clk_i(clk), .reset_i(reset), .frame_start_i(frame_start), .bypass_i(bypass),
    .inputs_i(inputs), .outputs_o(outputs), .dsp_start_o(dsp_start),
    .dsp_done_i(dsp_done), .busy_o(busy), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .rd_hit_o(rd_hit), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .overrun_count_o(overrun_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; bypass = 1'b0; dsp_done = 1'b0; wr_en = 1'b0;
    inputs = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_outputs", VW'(outputs), '0);
    chk("reset_busy", VW'(busy), VW'(0));
    chk("reset_start", VW'(dsp_start), VW'(0));
    chk("reset_ovr", VW'(overrun_count), VW'(0));
    chk("reset_rdhit", VW'(rd_hit), VW'(0));

    // Frame 1: inputs i+1, back buffer still zero.
    for (int i = 0; i < NCH; i++) inputs[i] = DWW'(i + 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("f1_start", VW'(dsp_start), VW'(1));
    chk("f1_busy", VW'(busy), VW'(1));
    chk("f1_outputs", VW'(outputs), '0);
    rd_addr = {INS, 7'd3};
    tick();
    chk("f1_start_drop", VW'(dsp_start), VW'(0));
    chk("f1_rd_data", VW'(rd_data), VW'(4));
    chk("f1_rd_hit", VW'(rd_hit), VW'(1));

    // DSP writes its results.
    for (int i = 0; i < NCH; i++) begin
      wr_en = 1'b1; wr_addr = {OUTS, 7'(i)}; wr_data = DWW'(32'h100 + i);
      tick();
    end
    // Writes to the input window must not touch the shadow bank.
    wr_addr = {INS, 7'd0}; wr_data = DWW'(32'hDEAD);
    rd_addr = {INS, 7'd0};
    tick();
    wr_en = 1'b0;
    tick();
    chk("inseg_write_ignored", VW'(rd_data), VW'(1));
    dsp_done = 1'b1;
    tick();
    dsp_done = 1'b0;
    chk("f1_done_idle", VW'(busy), VW'(0));

    // Frame 2 publishes the written results.
    for (int i = 0; i < NCH; i++) inputs[i] = DWW'(32'h20 + i);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < NCH; i++) exp_out[i] = DWW'(32'h100 + i);
    chk("f2_outputs", VW'(outputs), VW'(exp_out));
    chk("f2_busy", VW'(busy), VW'(1));
    chk("f2_start", VW'(dsp_start), VW'(1));

    // Overrun three cycles after dsp_start, no dsp_done.
    tick(); tick();
    for (int i = 0; i < NCH; i++) inputs[i] = DWW'(32'h55);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("ovr_count1", VW'(overrun_count), VW'(1));
    chk("ovr_outputs_held", VW'(outputs), VW'(exp_out));
    chk("ovr_no_start", VW'(dsp_start), VW'(0));
    chk("ovr_busy", VW'(busy), VW'(1));
    rd_addr = {INS, 7'd3};
    tick();
    chk("ovr_shadow_held", VW'(rd_data), VW'(32'h23));

    // dsp_done and frame_start together, with a forwarded write to channel 2.
    for (int i = 0; i < NCH; i++) inputs[i] = DWW'(32'h30 + i);
    dsp_done = 1'b1; frame_start = 1'b1;
    wr_en = 1'b1; wr_addr = {OUTS, 7'd2}; wr_data = DWW'(32'hABC);
    tick();
    dsp_done = 1'b0; frame_start = 1'b0; wr_en = 1'b0;
    exp_out[2] = DWW'(32'hABC);
    chk("same_cycle_outputs", VW'(outputs), VW'(exp_out));
    chk("same_cycle_ovr", VW'(overrun_count), VW'(1));
    chk("same_cycle_start", VW'(dsp_start), VW'(1));

    // dsp_done during LAUNCH is ignored.
    dsp_done = 1'b1;
    tick();
    dsp_done = 1'b0;
    chk("done_in_launch", VW'(busy), VW'(1));
    dsp_done = 1'b1;
    tick();
    dsp_done = 1'b0;
    chk("done_in_run", VW'(busy), VW'(0));

    // Bypass frame.
    for (int i = 0; i < NCH; i++) inputs[i] = DWW'(32'h40 + i);
    inputs[5] = DWW'(7);
    bypass = 1'b1; frame_start = 1'b1;
    tick();
    bypass = 1'b0; frame_start = 1'b0;
    chk("bypass_outputs", VW'(outputs), VW'(inputs));

    // Read decode edges.
    rd_addr = {3'd0, 7'd3};
    tick();
    chk("rd_seg0_data", VW'(rd_data), VW'(0));
    chk("rd_seg0_hit", VW'(rd_hit), VW'(0));
    rd_addr = {INS, 7'd8};
    tick();
    chk("rd_idx_oob_data", VW'(rd_data), VW'(0));
    chk("rd_idx_oob_hit", VW'(rd_hit), VW'(0));
    rd_addr = {INS, 7'd5};
    tick();
    chk("rd_idx5", VW'(rd_data), VW'(7));

    // Saturation: five more overruns while running, count already 1.
    frame_start = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    frame_start = 1'b0;
    chk("ovr_saturate", VW'(overrun_count), VW'(3));

    // Reset mid-RUN.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_run_outputs", VW'(outputs), '0);
    chk("rst_run_busy", VW'(busy), VW'(0));
    chk("rst_run_ovr", VW'(overrun_count), VW'(0));
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("rst_next_start", VW'(dsp_start), VW'(1));
    chk("rst_next_outputs", VW'(outputs), '0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
